// File: rtl/vo_unpack.sv
// vo_unpack: turns 128-bit FIFO words (4 pixels each) into a ready/valid pixel stream
// with start-of-frame / end-of-line markers and a starvation counter.
module vo_unpack #(
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080
) (
    input  logic         ui_clk,
    input  logic         rst,
    input  logic [127:0] fifo_dout,
    input  logic         fifo_empty,
    output logic         fifo_rd_en,
    input  logic         frame_rst,
    output logic [23:0]  p_data,
    output logic         p_valid,
    input  logic         p_ready,
    output logic         p_sof,
    output logic         p_eol,
    output logic [15:0]  underflow_cnt
);
    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);

    logic [95:0]   act_q, act_d, nxt_q, nxt_d, word;
    logic          act_full_q, act_full_d, nxt_full_q, nxt_full_d;
    logic          pend_q, pend_d, started_q, started_d;
    logic [1:0]    lane_q, lane_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [15:0]   ucnt_q, ucnt_d;
    logic          xfer, x_last, y_last, act_load, unused_pad;

    // Only the low 24 bits of each 32-bit lane carry pixel data.
    assign word       = {fifo_dout[119:96], fifo_dout[87:64], fifo_dout[55:32], fifo_dout[23:0]};
    assign unused_pad = ^{fifo_dout[127:120], fifo_dout[95:88], fifo_dout[63:56], fifo_dout[31:24]};

    assign xfer       = act_full_q && p_ready;
    assign x_last     = x_q == XW'(H_ACTIVE - 1);
    assign y_last     = y_q == YW'(V_ACTIVE - 1);
    assign act_load   = !act_full_q || (xfer && lane_q == 2'd3);
    assign fifo_rd_en = !rst && !frame_rst && !fifo_empty && !pend_q && !nxt_full_q;

    assign p_valid       = act_full_q;
    assign p_data        = !act_full_q ? 24'd0 :
                           lane_q == 2'd0 ? act_q[95:72] :
                           lane_q == 2'd1 ? act_q[71:48] :
                           lane_q == 2'd2 ? act_q[47:24] : act_q[23:0];
    assign p_sof         = act_full_q && x_q == '0 && y_q == '0;
    assign p_eol         = act_full_q && x_last;
    assign underflow_cnt = ucnt_q;

    always_comb begin
        act_d      = act_q;
        act_full_d = act_full_q;
        nxt_d      = nxt_q;
        nxt_full_d = nxt_full_q;
        lane_d     = lane_q;
        x_d        = x_q;
        y_d        = y_q;
        started_d  = started_q;
        pend_d     = fifo_rd_en;
        ucnt_d     = (started_q && p_ready && !act_full_q && ucnt_q != 16'hFFFF) ? ucnt_q + 16'd1 : ucnt_q;
        if (xfer) begin
            lane_d     = lane_q + 2'd1;
            act_full_d = lane_q != 2'd3;
            x_d        = x_last ? '0 : x_q + XW'(1);
            y_d        = !x_last ? y_q : y_last ? '0 : y_q + YW'(1);
            started_d  = !(x_last && y_last);
        end
        // A returning read bypasses NEXT when ACTIVE is free and NEXT is empty.
        if (act_load && (nxt_full_q || pend_q)) begin
            act_d      = nxt_full_q ? nxt_q : word;
            act_full_d = 1'b1;
            lane_d     = 2'd0;
            nxt_full_d = 1'b0;
        end
        if (pend_q && !(act_load && !nxt_full_q)) begin
            nxt_d      = word;
            nxt_full_d = 1'b1;
        end
        if (frame_rst) begin
            act_full_d = 1'b0;
            nxt_full_d = 1'b0;
            pend_d     = 1'b0;
            lane_d     = 2'd0;
            x_d        = '0;
            y_d        = '0;
            started_d  = 1'b0;
        end
    end

    always_ff @(posedge ui_clk) begin
        if (rst) begin
            act_full_q <= 1'b0;
            nxt_full_q <= 1'b0;
            pend_q     <= 1'b0;
            started_q  <= 1'b0;
            lane_q     <= 2'd0;
            x_q        <= '0;
            y_q        <= '0;
            ucnt_q     <= 16'd0;
        end else begin
            act_full_q <= act_full_d;
            nxt_full_q <= nxt_full_d;
            pend_q     <= pend_d;
            started_q  <= started_d;
            lane_q     <= lane_d;
            x_q        <= x_d;
            y_q        <= y_d;
            ucnt_q     <= ucnt_d;
        end
    end

    always_ff @(posedge ui_clk) begin
        act_q <= act_d;
        nxt_q <= nxt_d;
    end
endmodule

// File: tb/tb_vo_unpack.sv
// tb_vo_unpack: directed bench for vo_unpack with a FIFO model and a transfer recorder.
module tb_vo_unpack;
    localparam int H = 8;
    localparam int V = 2;

    logic         ui_clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] fifo_dout = '0;
    logic         fifo_empty = 1'b1;
    logic         fifo_rd_en;
    logic         frame_rst = 1'b0;
    logic [23:0]  p_data;
    logic         p_valid;
    logic         p_ready = 1'b0;
    logic         p_sof;
    logic         p_eol;
    logic [15:0]  underflow_cnt;

    logic [127:0] fifo_q[$];
    logic [25:0]  rx_q[$];
    logic         hold_empty = 1'b1;
    logic         occ_chk = 1'b0;
    logic         last_rd = 1'b0, last_valid = 1'b0, prev_rd = 1'b0;
    int           popped = 0, viol = 0;
    int           passed = 0, total = 0;

    vo_unpack #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .ui_clk(ui_clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .frame_rst(frame_rst), .p_data(p_data), .p_valid(p_valid),
        .p_ready(p_ready), .p_sof(p_sof), .p_eol(p_eol), .underflow_cnt(underflow_cnt)
    );

    always #5 ui_clk = ~ui_clk;

    function automatic logic [127:0] mkw(int b);
        return {8'hA5, 24'(b), 8'h5A, 24'(b + 1), 8'hC3, 24'(b + 2), 8'h3C, 24'(b + 3)};
    endfunction

    task automatic load(int b, int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(mkw(b + 4 * i));
    endtask

    // One clock: called at a negedge, returns at the next negedge. Models a FIFO
    // whose read data appears just after the edge that samples fifo_rd_en.
    task automatic step();
        logic [127:0] w;
        logic pop;
        w = '0;
        fifo_empty = hold_empty || fifo_q.size() == 0;
        #1;
        last_rd = fifo_rd_en;
        last_valid = p_valid;
        if (fifo_rd_en && prev_rd) viol++;
        if (occ_chk && fifo_rd_en && popped * 4 - rx_q.size() > 4) viol++;
        prev_rd = fifo_rd_en;
        if (p_valid && p_ready && !frame_rst && !rst) rx_q.push_back({p_sof, p_eol, p_data});
        pop = fifo_rd_en && fifo_q.size() > 0;
        if (pop) begin
            w = fifo_q.pop_front();
            popped++;
        end
        @(posedge ui_clk);
        #1;
        if (pop) fifo_dout = w;
        fifo_empty = hold_empty || fifo_q.size() == 0;
        @(negedge ui_clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        frame_rst = 1'b0;
        p_ready = 1'b0;
        hold_empty = 1'b1;
        occ_chk = 1'b0;
        fifo_q.delete();
        rx_q.delete();
        popped = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        load(0, 4);
        hold_empty = 1'b0;
        p_ready = 1'b1;
        step();
        step();
        total++; if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); else passed++;
        total++; if (p_valid !== 1'b0) $display("FAIL reset_p_valid got=%b exp=0", p_valid); else passed++;
        total++; if (p_data !== 24'd0) $display("FAIL reset_p_data got=%h exp=0", p_data); else passed++;
        total++; if ({p_sof, p_eol} !== 2'b00) $display("FAIL reset_sof_eol got=%b exp=00", {p_sof, p_eol}); else passed++;
        total++; if (underflow_cnt !== 16'd0) $display("FAIL reset_underflow got=%0d exp=0", underflow_cnt); else passed++;
    endtask

    task automatic test_stream();
        int first_rd, first_v, gaps, derr, serr, eerr;
        first_rd = -1; first_v = -1; gaps = 0; derr = 0; serr = 0; eerr = 0;
        do_reset();
        load(0, 8);
        hold_empty = 1'b0;
        p_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            step();
            if (last_rd && first_rd < 0) first_rd = c;
            if (last_valid && first_v < 0) first_v = c;
            if (first_v >= 0 && !last_valid && rx_q.size() < 32) gaps++;
        end
        for (int i = 0; i < rx_q.size(); i++) begin
            if (rx_q[i][23:0] !== 24'(i)) derr++;
            if (rx_q[i][25] !== (i % 16 == 0)) serr++;
            if (rx_q[i][24] !== (i % 8 == 7)) eerr++;
        end
        total++; if (first_rd < 0 || first_v - first_rd != 2) $display("FAIL stream_latency rd=%0d valid=%0d exp_diff=2", first_rd, first_v); else passed++;
        total++; if (gaps != 0) $display("FAIL stream_gaps got=%0d exp=0", gaps); else passed++;
        total++; if (rx_q.size() != 32) $display("FAIL stream_count got=%0d exp=32", rx_q.size()); else passed++;
        total++; if (popped != 8) $display("FAIL stream_popped got=%0d exp=8", popped); else passed++;
        total++; if (derr != 0) $display("FAIL stream_data errors=%0d exp=0", derr); else passed++;
        total++; if (serr != 0) $display("FAIL stream_sof errors=%0d exp=0", serr); else passed++;
        total++; if (eerr != 0) $display("FAIL stream_eol errors=%0d exp=0", eerr); else passed++;
        total++; if (underflow_cnt !== 16'd0) $display("FAIL stream_end_underflow got=%0d exp=0", underflow_cnt); else passed++;
    endtask

    task automatic test_underflow();
        int c;
        do_reset();
        p_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        total++; if (underflow_cnt !== 16'd0) $display("FAIL uf_before_start got=%0d exp=0", underflow_cnt); else passed++;
        load(100, 1);
        hold_empty = 1'b0;
        c = 0;
        while (rx_q.size() < 4 && c < 20) begin
            step();
            c++;
        end
        total++; if (rx_q.size() != 4 || rx_q[0][23:0] !== 24'd100) $display("FAIL uf_word_rx count=%0d exp=4", rx_q.size()); else passed++;
        total++; if (underflow_cnt !== 16'd0) $display("FAIL uf_during_emit got=%0d exp=0", underflow_cnt); else passed++;
        for (int i = 0; i < 5; i++) step();
        total++; if (underflow_cnt !== 16'd5) $display("FAIL uf_starved got=%0d exp=5", underflow_cnt); else passed++;
        p_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        total++; if (underflow_cnt !== 16'd5) $display("FAIL uf_not_ready got=%0d exp=5", underflow_cnt); else passed++;
        frame_rst = 1'b1;
        step();
        frame_rst = 1'b0;
        p_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        total++; if (underflow_cnt !== 16'd5) $display("FAIL uf_after_frame_rst got=%0d exp=5", underflow_cnt); else passed++;
    endtask

    task automatic test_frame_rst();
        int c;
        logic [23:0] exp_px;
        do_reset();
        load(0, 4);
        hold_empty = 1'b0;
        p_ready = 1'b1;
        c = 0;
        while (rx_q.size() < 5 && c < 30) begin
            step();
            c++;
        end
        total++; if (p_valid !== 1'b1 || p_data !== 24'd5) $display("FAIL fr_at_x5 valid=%b data=%0d exp=1/5", p_valid, p_data); else passed++;
        exp_px = fifo_q.size() > 0 ? fifo_q[0][119:96] : 24'hFFFFFF;
        frame_rst = 1'b1;
        step();
        frame_rst = 1'b0;
        total++; if (last_rd !== 1'b0) $display("FAIL fr_rd_en got=%b exp=0", last_rd); else passed++;
        total++; if (p_valid !== 1'b0) $display("FAIL fr_flush_valid got=%b exp=0", p_valid); else passed++;
        c = 0;
        while (rx_q.size() < 7 && c < 20) begin
            step();
            c++;
        end
        total++; if (rx_q.size() < 7 || rx_q[5][23:0] !== exp_px || rx_q[5][25] !== 1'b1) $display("FAIL fr_restart count=%0d exp_data=%0d", rx_q.size(), exp_px); else passed++;
        total++; if (rx_q.size() < 7 || rx_q[6][23:0] !== 24'd13 || rx_q[6][25] !== 1'b0) $display("FAIL fr_second count=%0d exp_data=13", rx_q.size()); else passed++;
    endtask

    task automatic test_backpressure();
        int c, derr, serr, eerr, stab;
        logic stall;
        logic [25:0] held;
        derr = 0; serr = 0; eerr = 0; stab = 0; stall = 1'b0; held = '0;
        do_reset();
        viol = 0;
        load(0, 200);
        hold_empty = 1'b0;
        occ_chk = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (stall && {p_valid, p_sof, p_eol, p_data} !== {1'b1, held}) stab++;
            p_ready = 1'($urandom_range(0, 1));
            stall = p_valid && !p_ready;
            held = {p_sof, p_eol, p_data};
            step();
        end
        p_ready = 1'b1;
        c = 0;
        while (rx_q.size() < 800 && c < 1000) begin
            step();
            c++;
        end
        occ_chk = 1'b0;
        for (int i = 0; i < rx_q.size(); i++) begin
            if (rx_q[i][23:0] !== 24'(i)) derr++;
            if (rx_q[i][25] !== (i % 16 == 0)) serr++;
            if (rx_q[i][24] !== (i % 8 == 7)) eerr++;
        end
        total++; if (rx_q.size() != 800) $display("FAIL bp_count got=%0d exp=800", rx_q.size()); else passed++;
        total++; if (derr != 0) $display("FAIL bp_data errors=%0d exp=0", derr); else passed++;
        total++; if (serr + eerr != 0) $display("FAIL bp_markers sof_err=%0d eol_err=%0d exp=0", serr, eerr); else passed++;
        total++; if (stab != 0) $display("FAIL bp_stall_stable errors=%0d exp=0", stab); else passed++;
        total++; if (viol != 0) $display("FAIL bp_read_rule violations=%0d exp=0", viol); else passed++;
    endtask

    task automatic test_rst_mid();
        int c, first_rd, first_v, derr;
        first_rd = -1; first_v = -1; derr = 0;
        do_reset();
        load(0, 8);
        hold_empty = 1'b0;
        p_ready = 1'b1;
        c = 0;
        while (rx_q.size() < 2 && c < 20) begin
            step();
            c++;
        end
        total++; if (rx_q.size() != 2) $display("FAIL rm_pre count=%0d exp=2", rx_q.size()); else passed++;
        rst = 1'b1;
        step();
        total++; if ({fifo_rd_en, p_valid, p_sof, p_eol, p_data, underflow_cnt} !== '0) $display("FAIL rm_outputs got=%b exp=0", {fifo_rd_en, p_valid, p_sof, p_eol, p_data, underflow_cnt}); else passed++;
        fifo_q.delete();
        rx_q.delete();
        load(500, 2);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (last_rd && first_rd < 0) first_rd = k;
            if (last_valid && first_v < 0) first_v = k;
        end
        for (int i = 0; i < rx_q.size(); i++) if (rx_q[i][23:0] !== 24'(500 + i)) derr++;
        total++; if (first_rd < 0 || first_v - first_rd != 2) $display("FAIL rm_latency rd=%0d valid=%0d exp_diff=2", first_rd, first_v); else passed++;
        total++; if (rx_q.size() != 8 || derr != 0 || rx_q[0][25] !== 1'b1) $display("FAIL rm_restart count=%0d data_err=%0d exp=8/0", rx_q.size(), derr); else passed++;
    endtask

    initial begin
        void'($urandom(32'd7));
        @(negedge ui_clk);
        test_reset();
        test_stream();
        test_underflow();
        test_frame_rst();
        test_backpressure();
        test_rst_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
